disp_frame_check: RTL and testbench
===================================

# disp_frame_check

Display-stream sink that consumes the pixel-clock output of the display controller (coordinates, data enable, frame strobe, RGB at system colour depth) and produces a per-frame summary: measured active width and height, a CRC-16 of all active pixels, and error flags. Sits at the far end of the display interface in simulation and board self-test builds, alongside the SDL/board output path. Lets benches and on-board checkers compare rendered frames against golden CRCs without storing frames.

## Interface

- `BPC`, default 5: bits per colour channel on the input stream.
- `CORDW`, default 16: signed coordinate width in bits.
- `EXP_WIDTH`, default 672: expected active pixels per line.
- `EXP_HEIGHT`, default 384: expected active lines per frame.

- `clk_pix`, in, 1: pixel clock. One clock; all logic is on `clk_pix`.
- `rst_pix`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: checker enable. Low forces IDLE.
- `disp_x`, in, CORDW, signed: horizontal position.
- `disp_y`, in, CORDW, signed: vertical position.
- `disp_de`, in, 1: data enable, high in the active area.
- `disp_frame`, in, 1: one-cycle frame-start strobe.
- `disp_r`, `disp_g`, `disp_b`, in, BPC each: pixel colour.
- `rpt_valid`, out, 1: summary available.
- `rpt_ready`, in, 1: consumer accepts the summary.
- `rpt_crc`, out, 16: CRC of active pixels.
- `rpt_width`, out, CORDW: active pixels in the first active line.
- `rpt_height`, out, CORDW: active lines.
- `rpt_err`, out, 3: error flags. [0] width, [1] height, [2] coordinate.
- `rpt_overrun`, out, 1: sticky; an unaccepted summary was overwritten.
- `frame_count`, out, 16: summaries produced since reset. Wraps.

## Operation

- States:
  - IDLE: entered on reset or `enable` low.
  - SYNC: `enable` high; waiting for `disp_frame`.
  - ACTIVE: accumulating a frame.
- Transitions:
  - IDLE→SYNC when `enable` is high.
  - SYNC→ACTIVE on `disp_frame`.
  - ACTIVE→ACTIVE on `disp_frame`: closes the current frame, emits a summary, and restarts the accumulators.
  - Any state→IDLE when `enable` is low. A partial frame is discarded with no summary.
- A pixel with `disp_de` high in the same cycle as `disp_frame` belongs to the new frame.
- CRC:
  - Algorithm: CRC-16/CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Input word per active pixel: 16 bits, {1'b0, r, g, b} for BPC=5 (zero-padded at the MSB generally), processed MSB-first.
  - Throughput: one word per cycle, parallel update.
- Line tracking:
  - A line is a maximal run of `disp_de` high; it ends on the `disp_de` falling edge.
  - Line pixel count is CORDW wide and saturates.
  - The first line's count sets `rpt_width`.
  - Each completed line increments `rpt_height`.
- Errors, per frame:
  - Width (err[0]): any line count differs from `EXP_WIDTH`.
  - Height (err[1]): line count at frame close is not equal to `EXP_HEIGHT`.
  - Coordinate (err[2]): the first pixel of a line has `disp_x` ≠ 0; a subsequent pixel has `disp_x` ≠ previous+1; or `disp_y` ≠ line index.
  - A line still open at `disp_frame` is counted as a line, and its width is checked.
- Report register:
  - One-deep. A transfer occurs when `rpt_valid` and `rpt_ready` are both high.
  - New summary while valid and not accepted: the new summary replaces the old, `rpt_valid` stays high, and `rpt_overrun` is set.
  - Accept and new summary in the same cycle: the new summary loads, valid stays high, no overrun.
- `rpt_overrun` clears only on reset or in IDLE.

## Timing

- Reset values: state IDLE; all `rpt_*` outputs 0; `frame_count` 0; CRC accumulator 0xFFFF.
- Latency: `disp_frame` at cycle T gives `rpt_valid` high at T+1, with data for the frame that closed. `frame_count` increments at T+1.
- Report data is stable while `rpt_valid` is high and not accepted, except on overwrite.
- `rpt_valid` falls the cycle after acceptance, unless a new summary loads in that cycle.
- Reset asserted mid-frame: immediate asynchronous clear; no summary.

## Structure

- Package `disp_check_pkg`:
  - CRC polynomial and init constants.
  - Error-bit index constants.
  - Parallel `crc16_next(crc, word)` function.
  - State encoding.
- One sub-module, `crc16_par`: combinational 16-bit-per-cycle CRC update, reusable by other checkers.
- Top level holds the FSM, line/coordinate trackers, and report register.

## Test plan

- Bench setup: `EXP_WIDTH`=4, `EXP_HEIGHT`=2, model display stream.
- Clean 4×2 frame, pixel value = x+4y → `rpt_width`=4, `rpt_height`=2, `rpt_err`=0, CRC equals the bench model (bytes hi,lo, CCITT-FALSE), `rpt_valid` at T+1.
- Frame with no `disp_de` → `rpt_crc`=0xFFFF, `rpt_width`=0, `rpt_height`=0, `rpt_err`=3'b011.
- Second line only 3 pixels wide → `rpt_width`=4, `rpt_err`=3'b001. Skipped `disp_x` (0,1,3,4) → err[2]=1.
- `rpt_ready` held low across two frame strobes → second summary visible, `rpt_overrun`=1, `frame_count`=2. Accept and new summary in the same cycle → no overrun.
- `enable` dropped mid-frame, then raised → no summary; the first summary follows the second subsequent `disp_frame`. Async `rst_pix` mid-frame → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/disp_check_pkg.sv
// Shared constants, state encoding and the parallel CRC-16/CCITT step
// used by display-stream checkers.
package disp_check_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int ERR_WIDTH  = 0;
    localparam int ERR_HEIGHT = 1;
    localparam int ERR_COORD  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Unrolled MSB-first shift; synthesises to a flat XOR network.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/disp_frame_check_crc16_par.sv
// Combinational CRC-16/CCITT update consuming one 16-bit word per cycle.
module crc16_par
    import disp_check_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [15:0] word,
    output logic [15:0] next
);

    assign next = crc16_next(crc, word);

endmodule

// File: rtl/disp_frame_check.sv
// Display-stream sink: per-frame active size, pixel CRC and error flags,
// delivered through a one-deep valid/ready report register.
module disp_frame_check
    import disp_check_pkg::*;
#(
    parameter int BPC        = 5,
    parameter int CORDW      = 16,
    parameter int EXP_WIDTH  = 672,
    parameter int EXP_HEIGHT = 384
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    enable,
    input  logic signed [CORDW-1:0] disp_x,
    input  logic signed [CORDW-1:0] disp_y,
    input  logic                    disp_de,
    input  logic                    disp_frame,
    input  logic [BPC-1:0]          disp_r,
    input  logic [BPC-1:0]          disp_g,
    input  logic [BPC-1:0]          disp_b,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [15:0]             rpt_crc,
    output logic [CORDW-1:0]        rpt_width,
    output logic [CORDW-1:0]        rpt_height,
    output logic [2:0]              rpt_err,
    output logic                    rpt_overrun,
    output logic [15:0]             frame_count
);

    localparam logic [CORDW-1:0] EXP_W = CORDW'(EXP_WIDTH);
    localparam logic [CORDW-1:0] EXP_H = CORDW'(EXP_HEIGHT);
    localparam logic [CORDW-1:0] ONE   = CORDW'(1);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    state_t state, state_nx;

    logic [15:0]      crc_q, b_crc, n_crc, crc_step, pix_word;
    logic [CORDW-1:0] cnt_q, b_cnt, n_cnt;
    logic [CORDW-1:0] height_q, c_h, b_h;
    logic [CORDW-1:0] width_q, c_w, b_w;
    logic [CORDW-1:0] px_q, n_px;
    logic             in_q, b_in, n_in;
    logic             wset_q, c_wset, b_wset;
    logic             ew_q, c_ew, b_ew;
    logic             ec_q, b_ec, n_ec;
    logic             line_end, restart, run, close;
    logic [2:0]       fin_err;

    assign pix_word = 16'({disp_r, disp_g, disp_b});

    crc16_par u_crc (
        .crc  (b_crc),
        .word (pix_word),
        .next (crc_step)
    );

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   state_nx = ST_SYNC;
                ST_SYNC:   if (disp_frame) state_nx = ST_ACTIVE;
                ST_ACTIVE: state_nx = ST_ACTIVE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    assign close    = enable && (state == ST_ACTIVE) && disp_frame;
    assign restart  = enable && disp_frame && (state != ST_IDLE);
    assign run      = enable && ((state == ST_ACTIVE) || restart);
    // A frame strobe also terminates any line still open.
    assign line_end = in_q && (!disp_de || disp_frame);

    always_comb begin
        c_h    = height_q;
        c_w    = width_q;
        c_wset = wset_q;
        c_ew   = ew_q;
        if (line_end) begin
            c_h = sat_inc(height_q);
            if (!wset_q) begin
                c_w    = cnt_q;
                c_wset = 1'b1;
            end
            if (cnt_q != EXP_W) c_ew = 1'b1;
        end
    end

    always_comb begin
        b_crc  = crc_q;
        b_cnt  = line_end ? '0 : cnt_q;
        b_in   = line_end ? 1'b0 : in_q;
        b_h    = c_h;
        b_w    = c_w;
        b_wset = c_wset;
        b_ew   = c_ew;
        b_ec   = ec_q;
        if (restart) begin
            b_crc  = CRC_INIT;
            b_cnt  = '0;
            b_in   = 1'b0;
            b_h    = '0;
            b_w    = '0;
            b_wset = 1'b0;
            b_ew   = 1'b0;
            b_ec   = 1'b0;
        end
        n_crc = b_crc;
        n_cnt = b_cnt;
        n_in  = b_in;
        n_px  = px_q;
        n_ec  = b_ec;
        if (disp_de) begin
            n_crc = crc_step;
            n_cnt = b_in ? sat_inc(b_cnt) : ONE;
            n_in  = 1'b1;
            n_px  = disp_x;
            if (b_in ? (disp_x != px_q + ONE) : (disp_x != '0)) n_ec = 1'b1;
            if (disp_y != b_h) n_ec = 1'b1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            crc_q <= CRC_INIT; cnt_q <= '0; height_q <= '0; width_q <= '0;
            px_q <= '0; in_q <= 1'b0; wset_q <= 1'b0; ew_q <= 1'b0;
            ec_q <= 1'b0;
        end else if (run) begin
            crc_q <= n_crc; cnt_q <= n_cnt; height_q <= b_h; width_q <= b_w;
            px_q <= n_px; in_q <= n_in; wset_q <= b_wset; ew_q <= b_ew;
            ec_q <= n_ec;
        end else begin
            crc_q <= CRC_INIT; cnt_q <= '0; height_q <= '0; width_q <= '0;
            px_q <= '0; in_q <= 1'b0; wset_q <= 1'b0; ew_q <= 1'b0;
            ec_q <= 1'b0;
        end
    end

    always_comb begin
        fin_err             = '0;
        fin_err[ERR_WIDTH]  = c_ew || (c_w != EXP_W);
        fin_err[ERR_HEIGHT] = (c_h != EXP_H);
        fin_err[ERR_COORD]  = ec_q;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            rpt_valid   <= 1'b0;
            rpt_crc     <= '0;
            rpt_width   <= '0;
            rpt_height  <= '0;
            rpt_err     <= '0;
            rpt_overrun <= 1'b0;
            frame_count <= '0;
        end else begin
            if (close) begin
                rpt_valid   <= 1'b1;
                rpt_crc     <= crc_q;
                rpt_width   <= c_w;
                rpt_height  <= c_h;
                rpt_err     <= fin_err;
                frame_count <= frame_count + 16'd1;
                if (rpt_valid && !rpt_ready) rpt_overrun <= 1'b1;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            if (state == ST_IDLE) rpt_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_frame_check.sv
// Bench for disp_frame_check with a 4x2 expected frame geometry.
module tb_disp_frame_check;

    localparam int BPC   = 5;
    localparam int CORDW = 16;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix;
    logic                    enable;
    logic signed [CORDW-1:0] disp_x, disp_y;
    logic                    disp_de, disp_frame;
    logic [BPC-1:0]          disp_r, disp_g, disp_b;
    logic                    rpt_valid, rpt_ready, rpt_overrun;
    logic [15:0]             rpt_crc, frame_count;
    logic [CORDW-1:0]        rpt_width, rpt_height;
    logic [2:0]              rpt_err;

    disp_frame_check #(
        .BPC(BPC), .CORDW(CORDW), .EXP_WIDTH(4), .EXP_HEIGHT(2)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .enable(enable),
        .disp_x(disp_x), .disp_y(disp_y), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g),
        .disp_b(disp_b), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_crc(rpt_crc), .rpt_width(rpt_width), .rpt_height(rpt_height),
        .rpt_err(rpt_err), .rpt_overrun(rpt_overrun),
        .frame_count(frame_count)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic [15:0] crc;
        int          w;
        int          h;
        logic [2:0]  err;
        int          fc;
    } exp_t;

    typedef struct {
        int         nl;
        int         w0, w1, w2;
        bit         skip;
        int         ew, eh;
        logic [2:0] eerr;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] m_crc = 16'hFFFF;
    int          fc_exp = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC-16/CCITT-FALSE, fed byte-wise (hi then lo).
    function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                             input logic [7:0] b);
        c = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int x, input int y);
        logic [15:0] w;
        w = 16'(x + 4 * y) & 16'h7FFF;
        disp_de = 1'b1;
        disp_x  = 16'(x);
        disp_y  = 16'(y);
        {disp_r, disp_g, disp_b} = w[14:0];
        m_crc = crc_byte(crc_byte(m_crc, w[15:8]), w[7:0]);
        tick();
        disp_de = 1'b0;
    endtask

    task automatic strobe();
        disp_frame = 1'b1;
        tick();
        disp_frame = 1'b0;
        m_crc = 16'hFFFF;
    endtask

    task automatic close(input int w, input int h, input logic [2:0] e);
        exp_t r;
        fc_exp++;
        r.crc = m_crc; r.w = w; r.h = h; r.err = e; r.fc = fc_exp;
        sb.push_back(r);
        strobe();
    endtask

    task automatic frame(input int nl, input int w0, input int w1,
                         input int w2, input bit skip);
        int wl, x;
        if (nl == 0) idle(3);
        for (int l = 0; l < nl; l++) begin
            wl = (l == 0) ? w0 : ((l == 1) ? w1 : w2);
            for (int p = 0; p < wl; p++) begin
                x = (skip && l == 0 && p >= 2) ? p + 1 : p;
                pix(x, l);
            end
            if (l < nl - 1) idle(2);
        end
    endtask

    task automatic expect_report(input string tag);
        exp_t r;
        chk({tag, ".valid"}, rpt_valid, 1);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.sb: got empty queue, expected entry", tag);
        end else begin
            r = sb.pop_front();
            chk({tag, ".crc"}, rpt_crc, r.crc);
            chk({tag, ".width"}, rpt_width, r.w);
            chk({tag, ".height"}, rpt_height, r.h);
            chk({tag, ".err"}, rpt_err, r.err);
            chk({tag, ".fc"}, frame_count, r.fc);
        end
    endtask

    task automatic accept();
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_pix = 1'b1;
        tick();
        rst_pix = 1'b0;
        sb.delete();
        fc_exp = 0;
        m_crc  = 16'hFFFF;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{2, 4, 4, 0, 1'b0, 4, 2, 3'b000};
        vt[1] = '{0, 0, 0, 0, 1'b0, 0, 0, 3'b011};
        vt[2] = '{2, 4, 3, 0, 1'b0, 4, 2, 3'b001};
        vt[3] = '{2, 4, 4, 0, 1'b1, 4, 2, 3'b100};
        vt[4] = '{3, 4, 4, 4, 1'b0, 4, 3, 3'b010};
        vt[5] = '{2, 2, 4, 0, 1'b0, 2, 2, 3'b001};

        rst_pix = 1'b1; enable = 1'b0; disp_de = 1'b0; disp_frame = 1'b0;
        disp_x = '0; disp_y = '0; disp_r = '0; disp_g = '0; disp_b = '0;
        rpt_ready = 1'b0;
        idle(2);
        chk("rst.valid", rpt_valid, 0);
        chk("rst.crc", rpt_crc, 0);
        chk("rst.width", rpt_width, 0);
        chk("rst.height", rpt_height, 0);
        chk("rst.err", rpt_err, 0);
        chk("rst.overrun", rpt_overrun, 0);
        chk("rst.fc", frame_count, 0);
        rst_pix = 1'b0;
        enable  = 1'b1;
        idle(2);
        strobe();
        chk("sync.novalid", rpt_valid, 0);

        for (int i = 0; i < 6; i++) begin
            frame(vt[i].nl, vt[i].w0, vt[i].w1, vt[i].w2, vt[i].skip);
            close(vt[i].ew, vt[i].eh, vt[i].eerr);
            expect_report($sformatf("vec%0d", i));
            accept();
            chk($sformatf("vec%0d.drop", i), rpt_valid, 0);
        end

        // Two summaries without acceptance.
        do_reset();
        idle(2);
        strobe();
        frame(2, 4, 4, 0, 1'b0);
        close(4, 2, 3'b000);
        expect_report("ovr1");
        chk("ovr1.flag", rpt_overrun, 0);
        idle(3);
        close(0, 0, 3'b011);
        chk("ovr2.flag", rpt_overrun, 1);
        expect_report("ovr2");
        accept();

        // Acceptance coinciding with a new summary.
        do_reset();
        idle(2);
        strobe();
        frame(2, 4, 4, 0, 1'b0);
        close(4, 2, 3'b000);
        expect_report("acc1");
        frame(2, 4, 4, 0, 1'b0);
        rpt_ready = 1'b1;
        close(4, 2, 3'b000);
        rpt_ready = 1'b0;
        expect_report("acc2");
        chk("acc2.noovr", rpt_overrun, 0);
        accept();

        // Enable dropped mid-frame discards the partial frame.
        pix(0, 0);
        pix(1, 0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        idle(2);
        chk("en.novalid", rpt_valid, 0);
        strobe();
        chk("en.strobe1.novalid", rpt_valid, 0);
        chk("en.strobe1.fc", frame_count, fc_exp);
        frame(2, 4, 4, 0, 1'b0);
        close(4, 2, 3'b000);
        expect_report("en");

        // Asynchronous reset in the middle of a frame.
        pix(0, 0);
        #3 rst_pix = 1'b1;
        #1;
        chk("arst.valid", rpt_valid, 0);
        chk("arst.crc", rpt_crc, 0);
        chk("arst.width", rpt_width, 0);
        chk("arst.height", rpt_height, 0);
        chk("arst.err", rpt_err, 0);
        chk("arst.fc", frame_count, 0);
        rst_pix = 1'b0;
        tick();
        chk("sb.empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
